// File: rtl/alu_decoder.sv
// alu_decoder: instruction-decode stage fused with the ALU of the single-cycle CPU.
//
// Registers the ROM word on each rising clk. The registered word is then decoded
// combinationally into the following outputs:
//   - register-file addresses
//   - argument-bus selects
//   - immediates
//   - unit chip-selects
//   - optype
// The ALU result is computed combinationally from the two argument buses.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   instr                instruction word at rom[ip]
//   adata1, adata2       ALU argument buses (lhs, rhs)
//   aluout               ALU result, mod 2^CELL_SIZE
//   alu_out, comp_out    output-bus drivers (ALU / comparator)
//   misc_cs, maybe_jmp   misc/IO chip-select, jump unit active
//   ip_incr, reg_we      advance instruction pointer, register-file write enable
//   use_r1, use_r2       bus takes register data (else the immediate)
//   r1_addr, r2_addr     register-file read addresses
//   rw_addr              register-file write address
//   default_a1/a2        zero-extended immediates for bus 1 / bus 2
//   optype               sub-operation for the selected unit
module alu_decoder #(
   parameter int unsigned CELL_SIZE = 16,
   parameter int unsigned ADDR_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [31:0]          instr,
   input  logic [CELL_SIZE-1:0] adata1,
   input  logic [CELL_SIZE-1:0] adata2,
   output logic [CELL_SIZE-1:0] aluout,
   output logic                 alu_out,
   output logic                 comp_out,
   output logic                 misc_cs,
   output logic                 maybe_jmp,
   output logic                 ip_incr,
   output logic                 reg_we,
   output logic                 use_r1,
   output logic                 use_r2,
   output logic [ADDR_SIZE-1:0] r1_addr,
   output logic [ADDR_SIZE-1:0] r2_addr,
   output logic [ADDR_SIZE-1:0] rw_addr,
   output logic [CELL_SIZE-1:0] default_a1,
   output logic [CELL_SIZE-1:0] default_a2,
   output logic [3:0]           optype
);

   typedef enum logic [1:0] {
      ClsAlu  = 2'b00,
      ClsComp = 2'b01,
      ClsMisc = 2'b10,
      ClsJump = 2'b11
   } cls_e;

   logic [31:0] ir_d, ir_q;
   logic        vld_d, vld_q;
   cls_e        cls;
   logic [2:0]  op;
   logic [3:0]  shamt;

   always_comb begin
      ir_d  = instr;
      vld_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ir_q  <= '0;
         vld_q <= 1'b0;
      end else begin
         ir_q  <= ir_d;
         vld_q <= vld_d;
      end
   end

   // Field decode: follows ir directly, so the reset value decodes like any other word.
   always_comb begin
      cls        = cls_e'(ir_q[31:30]);
      optype     = ir_q[29:26];
      use_r1     = ir_q[25];
      use_r2     = ir_q[24];
      rw_addr    = ADDR_SIZE'(ir_q[23:20]);
      r1_addr    = ADDR_SIZE'(ir_q[19:16]);
      r2_addr    = ADDR_SIZE'(ir_q[3:0]);
      default_a1 = CELL_SIZE'(ir_q[19:16]);
      default_a2 = CELL_SIZE'(ir_q[15:0]);
   end

   // Strobes: exactly one unit select while vld; everything low until the first load.
   always_comb begin
      alu_out   = 1'b0;
      comp_out  = 1'b0;
      misc_cs   = 1'b0;
      maybe_jmp = 1'b0;
      ip_incr   = 1'b0;
      reg_we    = 1'b0;
      if (vld_q) begin
         // The jump unit overrides ip_incr itself when it takes the branch.
         ip_incr = 1'b1;
         unique case (cls)
            ClsAlu:  begin alu_out   = 1'b1; reg_we = 1'b1; end
            ClsComp: begin comp_out  = 1'b1; reg_we = 1'b1; end
            ClsMisc: begin misc_cs   = 1'b1; reg_we = 1'b1; end
            ClsJump: begin maybe_jmp = 1'b1; end
            default: ;
         endcase
      end
   end

   // ALU: optype[0] is a don't-care; shift amount wraps at 16.
   always_comb begin
      op     = optype[3:1];
      shamt  = adata2[3:0];
      aluout = '0;
      unique case (op)
         3'b000:  aluout = adata1 + adata2;
         3'b001:  aluout = adata1 - adata2;
         3'b010:  aluout = adata1 & adata2;
         3'b011:  aluout = adata1 | adata2;
         3'b100:  aluout = adata1 ^ adata2;
         3'b101:  aluout = adata1 << shamt;
         3'b110:  aluout = adata1 >> shamt;
         3'b111:  aluout = ~adata1;
         default: aluout = '0;
      endcase
   end

endmodule

// File: tb/tb_alu_decoder.sv
// tb_alu_decoder: directed-vector bench for alu_decoder.
module tb_alu_decoder;

   logic        clk;
   logic        rstn;
   logic [31:0] instr;
   logic [15:0] adata1, adata2;
   logic [15:0] aluout;
   logic        alu_out, comp_out, misc_cs, maybe_jmp, ip_incr, reg_we;
   logic        use_r1, use_r2;
   logic [3:0]  r1_addr, r2_addr, rw_addr;
   logic [15:0] default_a1, default_a2;
   logic [3:0]  optype;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   alu_decoder #(
      .CELL_SIZE(16),
      .ADDR_SIZE(4)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .instr      (instr),
      .adata1     (adata1),
      .adata2     (adata2),
      .aluout     (aluout),
      .alu_out    (alu_out),
      .comp_out   (comp_out),
      .misc_cs    (misc_cs),
      .maybe_jmp  (maybe_jmp),
      .ip_incr    (ip_incr),
      .reg_we     (reg_we),
      .use_r1     (use_r1),
      .use_r2     (use_r2),
      .r1_addr    (r1_addr),
      .r2_addr    (r2_addr),
      .rw_addr    (rw_addr),
      .default_a1 (default_a1),
      .default_a2 (default_a2),
      .optype     (optype)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe vector order: {alu_out, comp_out, misc_cs, maybe_jmp, ip_incr, reg_we}
   function automatic logic [5:0] strobes();
      return {alu_out, comp_out, misc_cs, maybe_jmp, ip_incr, reg_we};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Drive a word between edges, then sample just after the loading edge.
   task automatic load(input logic [31:0] w);
      @(negedge clk);
      instr = w;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0]  opt;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp;
      string       tag;
   } alu_vec_t;

   alu_vec_t alu_vecs[$];

   initial begin
      alu_vecs.push_back('{4'b0010, 16'h0000, 16'h0001, 16'hFFFF, "sub_wrap"});
      alu_vecs.push_back('{4'b0000, 16'hFFFF, 16'h0002, 16'h0001, "add_wrap"});
      alu_vecs.push_back('{4'b1010, 16'h0001, 16'h0013, 16'h0008, "shl_3"});
      alu_vecs.push_back('{4'b1100, 16'h8000, 16'h000F, 16'h0001, "shr_15"});
      alu_vecs.push_back('{4'b0101, 16'hF0F0, 16'h3CC3, 16'h30C0, "and_bit0"});
      alu_vecs.push_back('{4'b0111, 16'hF0F0, 16'h0F01, 16'hFFF1, "or"});
      alu_vecs.push_back('{4'b1001, 16'hFFFF, 16'h1234, 16'hEDCB, "xor"});
      alu_vecs.push_back('{4'b1110, 16'h00FF, 16'h1234, 16'hFF00, "not"});
      alu_vecs.push_back('{4'b1011, 16'h0003, 16'h0010, 16'h0003, "shl_16"});

      rstn   = 1'b0;
      instr  = 32'h0000_0000;
      adata1 = '0;
      adata2 = '0;

      // Reset held over several edges: nothing loads, strobes stay low.
      repeat (3) @(posedge clk);
      #1;
      check("rst_strobes", 32'(strobes()), 32'h0);
      check("rst_optype", 32'(optype), 32'h0);
      check("rst_def_a2", 32'(default_a2), 32'h0);

      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("first_edge_strobes", 32'(strobes()), 32'b100011);

      // ALU add through the immediate path.
      load(32'h0012_0005);
      check("add_optype", 32'(optype), 32'h0);
      check("add_rw_addr", 32'(rw_addr), 32'h1);
      check("add_r1_addr", 32'(r1_addr), 32'h2);
      check("add_r2_addr", 32'(r2_addr), 32'h5);
      check("add_def_a1", 32'(default_a1), 32'h2);
      check("add_def_a2", 32'(default_a2), 32'h5);
      check("add_use_r", 32'({use_r1, use_r2}), 32'h0);
      adata1 = 16'd2;
      adata2 = 16'd5;
      #1;
      check("add_aluout", 32'(aluout), 32'h7);

      foreach (alu_vecs[i]) begin
         load({2'b00, alu_vecs[i].opt, 26'h0});
         adata1 = alu_vecs[i].a;
         adata2 = alu_vecs[i].b;
         #1;
         check(alu_vecs[i].tag, 32'(aluout), 32'(alu_vecs[i].exp));
      end

      // Class decode.
      load(32'hC300_0010);
      check("jmp_strobes", 32'(strobes()), 32'b000110);
      check("jmp_r2_addr", 32'(r2_addr), 32'h0);
      check("jmp_use_r", 32'({use_r1, use_r2}), 32'h3);
      check("jmp_def_a2", 32'(default_a2), 32'h0010);

      load(32'h4000_0000);
      check("comp_strobes", 32'(strobes()), 32'b010011);

      load(32'h8000_0000);
      check("misc_strobes", 32'(strobes()), 32'b001011);

      // Changing instr between edges must not disturb the decode.
      @(negedge clk);
      instr = 32'h7C00_0000;
      #2;
      check("latency_hold_strobes", 32'(strobes()), 32'b001011);
      check("latency_hold_optype", 32'(optype), 32'h0);
      @(posedge clk);
      #1;
      check("latency_load_strobes", 32'(strobes()), 32'b010011);
      check("latency_load_optype", 32'(optype), 32'hF);

      // Asynchronous reset mid-cycle clears immediately.
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("async_rst_strobes", 32'(strobes()), 32'h0);
      check("async_rst_optype", 32'(optype), 32'h0);
      #1;
      rstn = 1'b1;
      #1;
      check("post_rel_strobes", 32'(strobes()), 32'h0);
      @(posedge clk);
      #1;
      check("resume_strobes", 32'(strobes()), 32'b010011);
      check("resume_optype", 32'(optype), 32'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
